// File: rtl/sim_ctrl_pkg.sv
// Shared types and default signatures for the simulation run controller.
package sim_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RST_HOLD,
    RUN,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    V_NONE,
    V_PASS,
    V_FAIL,
    V_TIMEOUT
  } verdict_e;

  // Values a test program writes back to announce its own result.
  localparam logic [31:0] DEF_PASS_SIG = 32'h600D_600D;
  localparam logic [31:0] DEF_FAIL_SIG = 32'hBAD0_BAD0;

endpackage

// File: rtl/chan_sig_detect.sv
// Per-channel signature comparator: flags a valid writeback carrying the
// pass or fail signature. Purely combinational.
module chan_sig_detect
  import sim_ctrl_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] PASS_SIG = DATA_W'(DEF_PASS_SIG),
  parameter logic [DATA_W-1:0] FAIL_SIG = DATA_W'(DEF_FAIL_SIG)
) (
  input  logic              valid,
  input  logic [DATA_W-1:0] data,
  output logic              hit_pass,
  output logic              hit_fail
);

  assign hit_pass = valid && (data == PASS_SIG);
  assign hit_fail = valid && (data == FAIL_SIG);

endmodule

// File: rtl/sim_run_ctrl.sv
// Run controller for riscv simulation tops: holds the cores in reset for a
// fixed number of cycles, runs them under a cycle budget, watches the
// writeback streams for pass/fail signatures and latches a single verdict.
module sim_run_ctrl
  import sim_ctrl_pkg::*;
#(
  parameter int                NUM_CH     = 1,
  parameter int                DATA_W     = 32,
  parameter int                CNT_W      = 16,
  parameter int                RST_CYCLES = 1,
  parameter int                MAX_CYCLES = 40,
  parameter logic [DATA_W-1:0] PASS_SIG   = DATA_W'(DEF_PASS_SIG),
  parameter logic [DATA_W-1:0] FAIL_SIG   = DATA_W'(DEF_FAIL_SIG),
  localparam int               FCH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [NUM_CH-1:0]        wb_valid,
  input  logic [NUM_CH*DATA_W-1:0] wb_data,
  output logic                     core_reset,
  output logic                     running,
  output logic                     done,
  output logic                     pass,
  output logic                     fail,
  output logic                     timeout,
  output logic [FCH_W-1:0]         fail_ch,
  output logic [CNT_W-1:0]         cycle_cnt
);

  localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  state_e              r_state;
  state_e              w_next_state;
  verdict_e            r_verdict;
  verdict_e            w_verdict;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic [CNT_W-1:0]    r_cycle_cnt;
  logic [CNT_W-1:0]    w_cnt_inc;
  logic [NUM_CH-1:0]   r_pass_seen;
  logic [FCH_W-1:0]    r_fail_ch;
  logic [FCH_W-1:0]    w_fail_idx;
  logic [NUM_CH-1:0]   w_hit_pass;
  logic [NUM_CH-1:0]   w_hit_fail;
  logic                w_start_run;
  logic                w_any_fail;
  logic                w_all_pass;
  logic                w_budget_hit;

  // One comparator per monitored writeback channel.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    chan_sig_detect #(
      .DATA_W   (DATA_W),
      .PASS_SIG (PASS_SIG),
      .FAIL_SIG (FAIL_SIG)
    ) u_det (
      .valid    (wb_valid[g]),
      .data     (wb_data[g*DATA_W +: DATA_W]),
      .hit_pass (w_hit_pass[g]),
      .hit_fail (w_hit_fail[g])
    );
  end

  assign w_any_fail   = |w_hit_fail;
  // A pass arriving this cycle completes the set without waiting for pass_seen.
  assign w_all_pass   = &(r_pass_seen | w_hit_pass);
  assign w_budget_hit = (r_cycle_cnt == CNT_W'(MAX_CYCLES - 1));
  assign w_cnt_inc    = (&r_cycle_cnt) ? r_cycle_cnt : r_cycle_cnt + 1'b1;

  // Lowest failing channel wins: scan from the top so lower indices overwrite.
  always_comb begin
    w_fail_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (w_hit_fail[i]) w_fail_idx = FCH_W'(i);
    end
  end

  // Next-state and verdict selection; verdict priority is fail > pass > timeout.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    w_next_state = r_state;
    w_start_run  = 1'b0;
    w_verdict    = V_NONE;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_next_state = RST_HOLD;
          w_start_run  = 1'b1;
        end
      end
      RST_HOLD: begin
        if (r_hold_cnt == '0) w_next_state = RUN;
      end
      RUN: begin
        if (w_any_fail)        w_verdict = V_FAIL;
        else if (w_all_pass)   w_verdict = V_PASS;
        else if (w_budget_hit) w_verdict = V_TIMEOUT;
        if (w_verdict != V_NONE) w_next_state = DONE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // Hold counter, cycle counter, pass tracking and verdict registers.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: reset clears every register here, including verdict and
    // pass_seen, so an aborted run leaves nothing behind.
    if (!reset) begin
      r_hold_cnt  <= '0;
      r_cycle_cnt <= '0;
      r_pass_seen <= '0;
      r_verdict   <= V_NONE;
      r_fail_ch   <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_start_run) begin
            r_hold_cnt  <= HOLD_W'(RST_CYCLES - 1);
            r_cycle_cnt <= '0;
            r_pass_seen <= '0;
            r_verdict   <= V_NONE;
            r_fail_ch   <= '0;
          end
        end
        RST_HOLD: begin
          if (r_hold_cnt != '0) r_hold_cnt <= r_hold_cnt - 1'b1;
          r_cycle_cnt <= '0;
        end
        RUN: begin
          // On the exit cycle the increment makes cycle_cnt the elapsed count.
          r_cycle_cnt <= w_cnt_inc;
          r_pass_seen <= r_pass_seen | w_hit_pass;
          if (w_verdict != V_NONE) begin
            r_verdict <= w_verdict;
            if (w_verdict == V_FAIL) r_fail_ch <= w_fail_idx;
          end
        end
        default: ;
      endcase
    end
  end

  assign core_reset = (r_state != RUN);
  assign running    = (r_state == RUN);
  assign done       = (r_state == DONE);
  assign pass       = (r_verdict == V_PASS);
  assign fail       = (r_verdict == V_FAIL);
  assign timeout    = (r_verdict == V_TIMEOUT);
  assign fail_ch    = r_fail_ch;
  assign cycle_cnt  = r_cycle_cnt;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Directed bench for sim_run_ctrl: a default single-channel instance and a
// four-channel instance with a three-cycle reset hold, sharing clock and reset.
module tb_sim_run_ctrl;

  localparam logic [31:0] PSIG = 32'h600D_600D;
  localparam logic [31:0] FSIG = 32'hBAD0_BAD0;

  // Flag vector order: {core_reset, running, done, pass, fail, timeout}.
  localparam logic [5:0] F_HOLD = 6'b100000;
  localparam logic [5:0] F_RUN  = 6'b010000;
  localparam logic [5:0] F_PASS = 6'b101100;
  localparam logic [5:0] F_FAIL = 6'b101010;
  localparam logic [5:0] F_TMO  = 6'b101001;

  logic         clk;
  logic         reset;

  logic         start_a;
  logic [0:0]   wb_valid_a;
  logic [31:0]  wb_data_a;
  logic         core_reset_a, running_a, done_a, pass_a, fail_a, timeout_a;
  logic [0:0]   fail_ch_a;
  logic [15:0]  cycle_cnt_a;

  logic         start_b;
  logic [3:0]   wb_valid_b;
  logic [127:0] wb_data_b;
  logic         core_reset_b, running_b, done_b, pass_b, fail_b, timeout_b;
  logic [1:0]   fail_ch_b;
  logic [15:0]  cycle_cnt_b;

  logic [5:0]   flags_a;
  logic [5:0]   flags_b;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  assign flags_a = {core_reset_a, running_a, done_a, pass_a, fail_a, timeout_a};
  assign flags_b = {core_reset_b, running_b, done_b, pass_b, fail_b, timeout_b};

  sim_run_ctrl u_dut_a (
    .clk        (clk),
    .reset      (reset),
    .start      (start_a),
    .wb_valid   (wb_valid_a),
    .wb_data    (wb_data_a),
    .core_reset (core_reset_a),
    .running    (running_a),
    .done       (done_a),
    .pass       (pass_a),
    .fail       (fail_a),
    .timeout    (timeout_a),
    .fail_ch    (fail_ch_a),
    .cycle_cnt  (cycle_cnt_a)
  );

  sim_run_ctrl #(
    .NUM_CH     (4),
    .RST_CYCLES (3)
  ) u_dut_b (
    .clk        (clk),
    .reset      (reset),
    .start      (start_b),
    .wb_valid   (wb_valid_b),
    .wb_data    (wb_data_b),
    .core_reset (core_reset_b),
    .running    (running_b),
    .done       (done_b),
    .pass       (pass_b),
    .fail       (fail_b),
    .timeout    (timeout_b),
    .fail_ch    (fail_ch_b),
    .cycle_cnt  (cycle_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n clocks; inputs change and outputs are sampled 1 ns after each edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_b(input logic [3:0] v, input logic [31:0] d0, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] d3);
    wb_valid_b = v;
    wb_data_b  = {d3, d2, d1, d0};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset      = 1'b0;
    start_a    = 1'b0;
    wb_valid_a = '0;
    wb_data_a  = '0;
    start_b    = 1'b0;
    drive_b(4'b0000, 0, 0, 0, 0);
    #3;
    check("rst_flags_a", 32'(flags_a), 32'(F_HOLD));
    check("rst_cnt_a", 32'(cycle_cnt_a), 0);
    check("rst_flags_b", 32'(flags_b), 32'(F_HOLD));
    tick(2);
    reset = 1'b1;

    // 1: no signatures, run to timeout
    tick(1);
    start_a = 1'b1;
    tick(1);
    check("t1_hold_flags", 32'(flags_a), 32'(F_HOLD));
    start_a = 1'b0;
    tick(1);
    check("t1_run_flags", 32'(flags_a), 32'(F_RUN));
    check("t1_run_cnt0", 32'(cycle_cnt_a), 0);
    tick(39);
    check("t1_last_run_flags", 32'(flags_a), 32'(F_RUN));
    check("t1_last_run_cnt", 32'(cycle_cnt_a), 39);
    tick(1);
    check("t1_tmo_flags", 32'(flags_a), 32'(F_TMO));
    check("t1_tmo_cnt", 32'(cycle_cnt_a), 40);
    tick(3);
    check("t1_tmo_hold_flags", 32'(flags_a), 32'(F_TMO));
    check("t1_tmo_hold_cnt", 32'(cycle_cnt_a), 40);

    // 2: pass on RUN cycle 10
    start_a = 1'b1;
    tick(1);
    check("t2_restart_flags", 32'(flags_a), 32'(F_HOLD));
    check("t2_restart_cnt", 32'(cycle_cnt_a), 0);
    start_a = 1'b0;
    tick(11);
    check("t2_cnt10", 32'(cycle_cnt_a), 10);
    wb_valid_a = 1'b1;
    wb_data_a  = PSIG;
    tick(1);
    check("t2_pass_flags", 32'(flags_a), 32'(F_PASS));
    check("t2_pass_cnt", 32'(cycle_cnt_a), 11);
    wb_valid_a = 1'b0;
    wb_data_a  = '0;

    // 4: pass on the last budget cycle wins over timeout
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    tick(40);
    check("t4_edge_cnt", 32'(cycle_cnt_a), 39);
    wb_valid_a = 1'b1;
    wb_data_a  = PSIG;
    tick(1);
    check("t4_edge_pass_flags", 32'(flags_a), 32'(F_PASS));
    check("t4_edge_pass_cnt", 32'(cycle_cnt_a), 40);
    wb_valid_a = 1'b0;
    start_a    = 1'b1;
    tick(1);
    start_a = 1'b0;
    tick(41);
    check("t4_late_tmo_flags", 32'(flags_a), 32'(F_TMO));
    wb_valid_a = 1'b1;
    tick(1);
    check("t4_late_pass_ignored", 32'(flags_a), 32'(F_TMO));
    wb_valid_a = 1'b0;
    wb_data_a  = '0;

    // 5: asynchronous reset mid-run
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    tick(21);
    check("t5_mid_cnt", 32'(cycle_cnt_a), 20);
    check("t5_mid_flags", 32'(flags_a), 32'(F_RUN));
    reset = 1'b0;
    #2;
    check("t5_async_flags", 32'(flags_a), 32'(F_HOLD));
    check("t5_async_cnt", 32'(cycle_cnt_a), 0);
    tick(1);
    reset = 1'b1;
    tick(1);
    check("t5_idle_after", 32'(flags_a), 32'(F_HOLD));
    start_a = 1'b1;
    tick(1);
    check("t5_restart_hold", 32'(flags_a), 32'(F_HOLD));
    start_a = 1'b0;
    tick(1);
    check("t5_restart_run", 32'(flags_a), 32'(F_RUN));

    // 3: four channels, pass completes only when the last channel reports
    start_b = 1'b1;
    tick(1);
    check("t3_hold1", 32'(flags_b), 32'(F_HOLD));
    start_b = 1'b0;
    tick(1);
    check("t3_hold2", 32'(flags_b), 32'(F_HOLD));
    tick(1);
    check("t3_hold3", 32'(flags_b), 32'(F_HOLD));
    tick(1);
    check("t3_run", 32'(flags_b), 32'(F_RUN));
    tick(5);
    check("t3_cnt5", 32'(cycle_cnt_b), 5);
    drive_b(4'b0101, PSIG, 0, PSIG, 0);
    tick(1);
    drive_b(4'b0000, 0, 0, 0, 0);
    check("t3_after_ch02", 32'(flags_b), 32'(F_RUN));
    tick(1);
    drive_b(4'b0010, 0, PSIG, 0, 0);
    tick(1);
    drive_b(4'b0000, 0, 0, 0, 0);
    check("t3_after_ch1", 32'(flags_b), 32'(F_RUN));
    tick(1);
    check("t3_cnt9", 32'(cycle_cnt_b), 9);
    drive_b(4'b1001, 32'h1234_5678, 0, 0, PSIG);
    tick(1);
    check("t3_pass_flags", 32'(flags_b), 32'(F_PASS));
    check("t3_pass_cnt", 32'(cycle_cnt_b), 10);
    drive_b(4'b0000, 0, 0, 0, 0);

    // 6 + fail: start held high through the run, fail and pass in one cycle
    start_b = 1'b1;
    tick(1);
    check("t6_clear_flags", 32'(flags_b), 32'(F_HOLD));
    tick(3);
    check("t6_run_flags", 32'(flags_b), 32'(F_RUN));
    tick(3);
    check("t6_no_restart_cnt", 32'(cycle_cnt_b), 3);
    check("t6_no_restart_flags", 32'(flags_b), 32'(F_RUN));
    drive_b(4'b1100, 0, 0, FSIG, PSIG);
    tick(1);
    check("t3_fail_flags", 32'(flags_b), 32'(F_FAIL));
    check("t3_fail_ch", 32'(fail_ch_b), 2);
    check("t3_fail_cnt", 32'(cycle_cnt_b), 4);
    drive_b(4'b0000, 0, 0, 0, 0);
    tick(1);
    check("t6_restart_flags", 32'(flags_b), 32'(F_HOLD));
    check("t6_restart_fail_ch", 32'(fail_ch_b), 0);
    start_b = 1'b0;
    tick(3);
    check("t6_rerun_flags", 32'(flags_b), 32'(F_RUN));
    drive_b(4'b1010, 0, FSIG, 0, FSIG);
    tick(1);
    check("t6_low_fail_flags", 32'(flags_b), 32'(F_FAIL));
    check("t6_low_fail_ch", 32'(fail_ch_b), 1);
    check("t6_low_fail_cnt", 32'(cycle_cnt_b), 1);
    drive_b(4'b0000, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
